// File: rtl/soc_hpm_counters.sv
// Hardware performance counter bank: per-channel event counters with
// half-word writes, sticky overflow flags and a global snapshot copy.
module soc_hpm_counters #(
    parameter int NB_CNT     = 4,
    parameter int CNT_WIDTH  = 64,
    parameter bit CH0_CYCLES = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_sleep,
    input  logic [NB_CNT-1:0]             i_inhibit,
    input  logic [NB_CNT-1:0]             i_event,
    input  logic                          i_wr_en,
    input  logic [((NB_CNT > 1) ? $clog2(NB_CNT) : 1)-1:0] i_wr_sel,
    input  logic                          i_wr_hi,
    input  logic [31:0]                   i_wr_data,
    input  logic                          i_snap,
    input  logic [NB_CNT-1:0]             i_ovf_clr,
    output logic [NB_CNT*CNT_WIDTH-1:0]   o_count,
    output logic [NB_CNT*CNT_WIDTH-1:0]   o_snap,
    output logic                          o_snap_valid,
    output logic [NB_CNT-1:0]             o_ovf
);

    localparam int HI_W = CNT_WIDTH - 32;
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q  [NB_CNT];
    logic [CNT_WIDTH-1:0] cnt_d  [NB_CNT];
    logic [CNT_WIDTH-1:0] snap_q [NB_CNT];
    logic [CNT_WIDTH-1:0] snap_d [NB_CNT];
    logic [NB_CNT-1:0]    ovf_q;
    logic [NB_CNT-1:0]    ovf_d;
    logic                 snap_valid_q;
    logic                 snap_valid_d;

    logic [NB_CNT-1:0]    inc;
    logic [NB_CNT-1:0]    wr_hit;
    logic [NB_CNT-1:0]    wrap;

    always_comb begin
        inc          = '0;
        wr_hit       = '0;
        wrap         = '0;
        ovf_d        = ovf_q;
        snap_valid_d = snap_valid_q || i_snap;
        for (int k = 0; k < NB_CNT; k++) begin
            cnt_d[k]  = cnt_q[k];
            snap_d[k] = i_snap ? cnt_q[k] : snap_q[k];
            inc[k]    = !i_sleep && !i_inhibit[k] &&
                        (i_event[k] || ((k == 0) && CH0_CYCLES));
            wr_hit[k] = i_wr_en && (int'(i_wr_sel) == k);
            // A write owns the channel for this cycle: no count, no wrap.
            if (wr_hit[k]) begin
                if (i_wr_hi) begin
                    cnt_d[k][CNT_WIDTH-1:32] = i_wr_data[HI_W-1:0];
                end else begin
                    cnt_d[k][31:0] = i_wr_data;
                end
            end else if (inc[k]) begin
                cnt_d[k] = cnt_q[k] + ONE;
                wrap[k]  = &cnt_q[k];
            end
            ovf_d[k] = (ovf_q[k] && !i_ovf_clr[k]) || wrap[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NB_CNT; k++) begin
                cnt_q[k]  <= '0;
                snap_q[k] <= '0;
            end
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NB_CNT; k++) begin
                cnt_q[k]  <= cnt_d[k];
                snap_q[k] <= snap_d[k];
            end
            ovf_q        <= ovf_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    for (genvar g = 0; g < NB_CNT; g++) begin : g_out
        assign o_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
        assign o_snap[g*CNT_WIDTH +: CNT_WIDTH]  = snap_q[g];
    end

    assign o_ovf        = ovf_q;
    assign o_snap_valid = snap_valid_q;

endmodule

// File: doc/soc_hpm_counters.md
SOC_HPM_COUNTERS -- requirements
Module: soc_hpm_counters

Interface
REQ-001 Parameter NB_CNT, default 4, number of counter channels (1..8).
REQ-002 Parameter CNT_WIDTH, default 64, width of each counter (33..64).
REQ-003 Parameter CH0_CYCLES, default 1, channel 0 counts every clock (1) or i_event[0] (0).
REQ-004 i_clk  in  1  global clock; single clock domain.
REQ-005 i_rst  in  1  global reset, asynchronous, active-high.
REQ-006 i_sleep  in  1  active-high sleep; freezes all channels.
REQ-007 i_inhibit  in  NB_CNT  per-channel count inhibit, active-high.
REQ-008 i_event  in  NB_CNT  per-channel increment request, sampled each cycle.
REQ-009 i_wr_en  in  1  single-cycle counter write strobe.
REQ-010 i_wr_sel  in  $clog2(NB_CNT) (min 1)  channel index for write.
REQ-011 i_wr_hi  in  1  0: write bits [31:0]; 1: write bits [CNT_WIDTH-1:32].
REQ-012 i_wr_data  in  32  write data; high write uses i_wr_data[CNT_WIDTH-33:0].
REQ-013 i_snap  in  1  snapshot strobe; copies all counters to shadow registers.
REQ-014 i_ovf_clr  in  NB_CNT  per-channel overflow flag clear mask.
REQ-015 o_count  out  NB_CNT*CNT_WIDTH  live counter values, channel k at [k*CNT_WIDTH +: CNT_WIDTH].
REQ-016 o_snap  out  NB_CNT*CNT_WIDTH  snapshot values, same packing.
REQ-017 o_snap_valid  out  1  high from first snapshot until reset.
REQ-018 o_ovf  out  NB_CNT  sticky per-channel overflow flags.

Function
REQ-019 Channel k SHALL increment by 1 at a rising edge when inc_k = !i_sleep & !i_inhibit[k] & (i_event[k] | (k==0 & CH0_CYCLES)).
REQ-020 Increment SHALL be modulo 2^CNT_WIDTH; all-ones + 1 -> 0 and o_ovf[k] set the same edge.
REQ-021 o_ovf[k] SHALL stay set until cleared by i_ovf_clr[k]=1 at an edge; simultaneous wrap and clear -> flag set (set wins).
REQ-022 i_wr_en=1 SHALL load the selected half of channel i_wr_sel at the next edge; other half unchanged.
REQ-023 Write and increment of the same channel in the same cycle -> written value only, no increment, no overflow set.
REQ-024 Write to a half SHALL NOT carry into or out of the other half; writes with i_wr_sel >= NB_CNT SHALL be ignored.
REQ-025 Unwritten channels SHALL increment normally in a write cycle.
REQ-026 i_snap=1 SHALL copy all live counter values as they were before that edge (pre-increment, pre-write) into o_snap; o_snap_valid set.
REQ-027 o_snap SHALL hold between snapshots; i_sleep and i_inhibit do not affect snapshot.
REQ-028 o_count SHALL be the register value directly (no combinational path from inputs); update latency 1 cycle.
REQ-029 i_sleep=1 SHALL freeze increments but SHALL NOT block writes, snapshots or overflow clears.

Reset
REQ-030 On i_rst=1, asynchronously: all counters 0, o_snap 0, o_snap_valid 0, o_ovf 0.
REQ-031 Reset asserted mid-operation SHALL override any write, snapshot or increment in progress; counting resumes on the first edge after deassertion.

Verification
REQ-032 Reset release, CH0_CYCLES=1, no events, 10 clocks -> ch0=10, ch1..3=0, o_ovf=0.
REQ-033 Write ch2 lo=0xFFFF_FFFF, hi=0xFFFF_FFFF (64-bit), i_event[2]=1 one cycle -> ch2=0, o_ovf[2]=1; assert i_ovf_clr[2] with another wrap same cycle -> o_ovf[2] stays 1.
REQ-034 ch1=5, i_event[1]=1 and write ch1 lo=0x100 same cycle -> ch1=0x100 next cycle, hi unchanged.
REQ-035 ch0=41 counting, i_snap=1 -> o_snap ch0=41, o_count ch0=42, o_snap_valid=1; o_snap unchanged 20 cycles later.
REQ-036 i_sleep=1 for 8 cycles with all events high -> all counters unchanged; i_inhibit[3]=1 with i_event[3]=1 -> ch3 unchanged, others increment.
REQ-037 Assert i_rst asynchronously between edges while ch0=0x1234 -> o_count, o_snap, o_ovf read 0 before next edge.
